// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: drives a synchronous-read BRAM and handles stall/redirect.
// Optional FETCH_PERF_CNT_EN adds fetch and bubble performance counters.
module fetch_stage #(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
    parameter int                     IMEM_AW  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_id,
    input  logic                redirect_ex,
    input  logic [PC_WIDTH-1:0] redirect_pc_ex,
    output logic                imem_en,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                valid_id,
    output logic [31:0]         instr_id,
    output logic [PC_WIDTH-1:0] pc_id,
    output logic [6:0]          opcode_id,
    output logic [6:0]          funct7_id,
    output logic [2:0]          funct3_id,
    output logic [4:0]          rd_id,
    output logic [4:0]          rs1_id,
    output logic [4:0]          rs2_id
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_bubble_cnt
`endif
);

    logic [PC_WIDTH-1:0] pc_req_q, pc_req_d;
    logic                req_valid_q, req_valid_d;
    logic [PC_WIDTH-1:0] pc_resp_q, pc_resp_d;
    logic                resp_valid_q, resp_valid_d;
    logic                valid_id_q, valid_id_d;
    logic [31:0]         instr_id_q, instr_id_d;
    logic [PC_WIDTH-1:0] pc_id_q, pc_id_d;
    logic                advance;
    logic [PC_WIDTH-1:0] redirect_target;

    // A redirect overrides a stall: the wrong-path state must be flushed regardless.
    assign advance         = !stall_id || redirect_ex;
    assign redirect_target = redirect_pc_ex & ~PC_WIDTH'(3);

    always_comb begin
        pc_req_d     = pc_req_q;
        req_valid_d  = req_valid_q;
        pc_resp_d    = pc_resp_q;
        resp_valid_d = resp_valid_q;
        valid_id_d   = valid_id_q;
        instr_id_d   = instr_id_q;
        pc_id_d      = pc_id_q;
        if (advance) begin
            pc_resp_d  = pc_req_q;
            pc_id_d    = pc_resp_q;
            if (redirect_ex) begin
                pc_req_d     = redirect_target;
                req_valid_d  = 1'b1;
                resp_valid_d = 1'b0;
                valid_id_d   = 1'b0;
                instr_id_d   = 32'h0;
            end else begin
                pc_req_d     = pc_req_q + PC_WIDTH'(4);
                resp_valid_d = req_valid_q;
                valid_id_d   = resp_valid_q;
                instr_id_d   = resp_valid_q ? imem_rdata : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_req_q     <= RESET_PC;
            req_valid_q  <= 1'b1;
            pc_resp_q    <= '0;
            resp_valid_q <= 1'b0;
            valid_id_q   <= 1'b0;
            instr_id_q   <= 32'h0;
            pc_id_q      <= '0;
        end else begin
            pc_req_q     <= pc_req_d;
            req_valid_q  <= req_valid_d;
            pc_resp_q    <= pc_resp_d;
            resp_valid_q <= resp_valid_d;
            valid_id_q   <= valid_id_d;
            instr_id_q   <= instr_id_d;
            pc_id_q      <= pc_id_d;
        end
    end

    // Disabling the read during a stall keeps the pending word on imem_rdata.
    assign imem_en   = !rst && advance;
    assign imem_addr = pc_req_q[IMEM_AW+1:2];

    assign valid_id  = valid_id_q;
    assign instr_id  = instr_id_q;
    assign pc_id     = pc_id_q;
    assign opcode_id = instr_id_q[6:0];
    assign funct7_id = instr_id_q[31:25];
    assign funct3_id = instr_id_q[14:12];
    assign rd_id     = instr_id_q[11:7];
    assign rs1_id    = instr_id_q[19:15];
    assign rs2_id    = instr_id_q[24:20];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (advance) begin
            if (valid_id_d) perf_fetch_d  = perf_fetch_q + 32'd1;
            else            perf_bubble_d = perf_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset fill, stall hold, redirect flush, redirect+stall, async reset, PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_id;
    logic        redirect_ex;
    logic [31:0] redirect_pc_ex;
    logic        imem_en;
    logic [14:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        valid_id;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [6:0]  opcode_id;
    logic [6:0]  funct7_id;
    logic [2:0]  funct3_id;
    logic [4:0]  rd_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:32767];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_id       (stall_id),
        .redirect_ex    (redirect_ex),
        .redirect_pc_ex (redirect_pc_ex),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .valid_id       (valid_id),
        .instr_id       (instr_id),
        .pc_id          (pc_id),
        .opcode_id      (opcode_id),
        .funct7_id      (funct7_id),
        .funct3_id      (funct3_id),
        .rd_id          (rd_id),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word contents: the four program words, elsewhere "addi x5, x0, idx[11:0]".
    function automatic logic [31:0] word_at(input int idx);
        logic [31:0] w;
        logic [31:0] iv;
        iv = idx;
        case (idx)
            0:       w = 32'h0010_0093;
            1:       w = 32'h0020_0113;
            2:       w = 32'h0020_81b3;
            3:       w = 32'h0000_0013;
            default: w = {iv[11:0], 5'd0, 3'd0, 5'd5, 7'h13};
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = word_at(i);
        imem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle, drive that cycle's inputs, then settle before checks.
    task automatic next(input logic s, input logic r, input logic [31:0] t);
        @(posedge clk);
        #2;
        stall_id       = s;
        redirect_ex    = r;
        redirect_pc_ex = t;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_id = 1'b0; redirect_ex = 1'b0; redirect_pc_ex = 32'h0;
        #1;
        chk("rst_valid", valid_id, 0);
        chk("rst_instr", instr_id, 0);
        chk("rst_pc", pc_id, 0);
        chk("rst_en", imem_en, 0);
        chk("rst_opcode", opcode_id, 0);

        @(posedge clk); @(posedge clk); #2; rst = 1'b0; #1;
        chk("c0_en", imem_en, 1);
        chk("c0_addr", imem_addr, 0);
        chk("c0_valid", valid_id, 0);
        next(0, 0, 0);
        chk("c1_valid", valid_id, 0);
        chk("c1_addr", imem_addr, 1);
        next(0, 0, 0);
        chk("c2_valid", valid_id, 1);
        chk("c2_pc", pc_id, 0);
        chk("c2_instr", instr_id, 32'h0010_0093);
        chk("c2_opcode", opcode_id, 7'b0010011);

        next(1, 0, 0);
        chk("stall0_pc", pc_id, 4);
        chk("stall0_instr", instr_id, 32'h0020_0113);
        chk("stall0_opcode", opcode_id, 7'b0010011);
        chk("stall0_en", imem_en, 0);
        for (int k = 1; k < 3; k++) begin
            next(1, 0, 0);
            chk("stall_pc", pc_id, 4);
            chk("stall_instr", instr_id, 32'h0020_0113);
            chk("stall_en", imem_en, 0);
        end
        next(0, 0, 0);
        chk("release_pc", pc_id, 4);
        chk("release_en", imem_en, 1);
        next(0, 0, 0);
        chk("seq_pc8", pc_id, 8);
        chk("seq_instr8", instr_id, 32'h0020_81b3);
        chk("seq_opcode8", opcode_id, 7'b0110011);
        chk("f_rd", rd_id, 3);
        chk("f_rs1", rs1_id, 1);
        chk("f_rs2", rs2_id, 2);
        chk("f_funct3", funct3_id, 0);
        chk("f_funct7", funct7_id, 0);

        redirect_ex = 1'b1; redirect_pc_ex = 32'h40; #1;
        chk("redir_en", imem_en, 1);
        next(0, 0, 0);
        chk("bub1_valid", valid_id, 0);
        chk("bub1_instr", instr_id, 0);
        chk("bub1_opcode", opcode_id, 0);
        chk("bub1_addr", imem_addr, 15'h10);
        next(0, 0, 0);
        chk("bub2_valid", valid_id, 0);
        chk("bub2_instr", instr_id, 0);
        next(0, 0, 0);
        chk("tgt_valid", valid_id, 1);
        chk("tgt_pc", pc_id, 32'h40);
        chk("tgt_instr", instr_id, word_at(16));
        next(0, 0, 0);
        chk("tgt_pc44", pc_id, 32'h44);
        chk("tgt_instr44", instr_id, word_at(17));
        next(0, 0, 0);
        chk("tgt_pc48", pc_id, 32'h48);

        stall_id = 1'b1; redirect_ex = 1'b1; redirect_pc_ex = 32'h23; #1;
        chk("rs_en", imem_en, 1);
        next(0, 0, 0);
        chk("rs_bub1", valid_id, 0);
        chk("rs_addr", imem_addr, 8);
        next(0, 0, 0);
        chk("rs_bub2", valid_id, 0);
        next(0, 0, 0);
        chk("rs_valid", valid_id, 1);
        chk("rs_pc", pc_id, 32'h20);
        chk("rs_instr", instr_id, word_at(8));
        next(0, 0, 0);
        chk("rs_pc24", pc_id, 32'h24);

        redirect_ex = 1'b1; redirect_pc_ex = 32'h80; #1;
        next(0, 0, 0);
        chk("ar_bub", valid_id, 0);
        #2; rst = 1'b1; #1;
        chk("ar_valid", valid_id, 0);
        chk("ar_instr", instr_id, 0);
        chk("ar_pc", pc_id, 0);
        chk("ar_en", imem_en, 0);
        @(posedge clk); #2; rst = 1'b0; #1;
        chk("ar_c0_addr", imem_addr, 0);
        chk("ar_c0_en", imem_en, 1);
        next(0, 0, 0);
        chk("ar_c1_valid", valid_id, 0);
        next(0, 0, 0);
        chk("ar_c2_valid", valid_id, 1);
        chk("ar_c2_pc", pc_id, 0);
        chk("ar_c2_instr", instr_id, 32'h0010_0093);
        next(0, 1, 32'hFFFF_FFFC);
        chk("ar_c3_pc", pc_id, 4);
        next(0, 0, 0);
        chk("wrap_bub1", valid_id, 0);
        chk("wrap_addr", imem_addr, 15'h7FFF);
        next(0, 0, 0);
        chk("wrap_bub2", valid_id, 0);
        next(0, 0, 0);
        chk("wrap_pc_top", pc_id, 32'hFFFF_FFFC);
        chk("wrap_instr_top", instr_id, word_at(32767));
        next(0, 0, 0);
        chk("wrap_pc0", pc_id, 0);
        chk("wrap_instr0", instr_id, 32'h0010_0093);
        next(0, 0, 0);
        chk("wrap_pc4", pc_id, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
